// File: rtl/display_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment display path.
// Segment vectors are active-low in the order {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [0:0] {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph; non-decimal nibbles show a dash.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Glyph lookup
    always_comb begin
        seg_n = SEG_DASH;
        case (nibble)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Scans a 4-digit common-anode display from a captured packed-BCD value and
// periodically requests a fresh conversion, flagging stale when no answer arrives.
module bcd_sevenseg_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int UPDATE_TICKS = 250,
    parameter int TIMEOUT      = 128
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_vld,
    input  logic        blank_lz,
    output logic        conv_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        stale
);

    localparam int RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int UW = (UPDATE_TICKS > 1) ? $clog2(UPDATE_TICKS) : 1;
    localparam int TW = (TIMEOUT      > 1) ? $clog2(TIMEOUT)      : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [UW-1:0] UPDATE_LAST  = UW'(UPDATE_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    logic [RW-1:0] refresh_cnt_r;
    logic          tick_s;
    logic [1:0]    digit_idx_r;
    logic [15:0]   bcd_reg_r;

    req_state_e    state_r, state_nxt_s;
    logic [UW-1:0] upd_cnt_r, upd_cnt_nxt_s;
    logic [TW-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic          conv_en_r, conv_en_nxt_s;
    logic          stale_r, stale_nxt_s;

    logic [3:0]    nibble_s;
    logic [6:0]    glyph_s;
    logic          blank_s;
    logic [6:0]    seg_nxt_s;
    logic [3:0]    an_n_r;
    logic [6:0]    seg_n_r;
    logic          dp_n_r;

    assign tick_s = (refresh_cnt_r == REFRESH_LAST);

    // Digit-slot refresh counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_r <= '0;
        end else if (tick_s) begin
            refresh_cnt_r <= '0;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + RW'(1);
        end
    end

    // Descending digit index; 0 wraps back to 3 through the 2-bit subtract
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_idx_r <= 2'd0;
        end else if (tick_s) begin
            digit_idx_r <= digit_idx_r - 2'd1;
        end
    end

    // Result capture, accepted regardless of request state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_reg_r <= 16'h0000;
        end else if (bcd_vld) begin
            bcd_reg_r <= bcd_in;
        end
    end

    // Nibble select for the active digit
    always_comb begin
        nibble_s = bcd_reg_r[3:0];
        case (digit_idx_r)
            2'd0:    nibble_s = bcd_reg_r[3:0];
            2'd1:    nibble_s = bcd_reg_r[7:4];
            2'd2:    nibble_s = bcd_reg_r[11:8];
            2'd3:    nibble_s = bcd_reg_r[15:12];
            default: nibble_s = bcd_reg_r[3:0];
        endcase
    end

    bcd_to_seg7 u_seg7 (
        .nibble (nibble_s),
        .seg_n  (glyph_s)
    );

    // A digit is leading-zero blanked only if it and every more significant digit are zero
    always_comb begin
        blank_s = 1'b0;
        if (blank_lz) begin
            case (digit_idx_r)
                2'd3:    blank_s = (bcd_reg_r[15:12] == 4'd0);
                2'd2:    blank_s = (bcd_reg_r[15:8]  == 8'd0);
                2'd1:    blank_s = (bcd_reg_r[15:4]  == 12'd0);
                default: blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
        seg_nxt_s = blank_s ? SEG_BLANK : glyph_s;
    end

    // Registered display drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n_r  <= 4'hF;
            seg_n_r <= SEG_BLANK;
            dp_n_r  <= 1'b1;
        end else begin
            an_n_r  <= anode_sel(digit_idx_r);
            seg_n_r <= seg_nxt_s;
            dp_n_r  <= ~((digit_idx_r == 2'd0) && stale_r);
        end
    end

    // Request FSM next-state; a capture in the timeout cycle takes precedence
    always_comb begin
        state_nxt_s    = state_r;
        upd_cnt_nxt_s  = upd_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;
        conv_en_nxt_s  = 1'b0;
        stale_nxt_s    = stale_r;
        case (state_r)
            REQ_IDLE: begin
                if (tick_s) begin
                    if (upd_cnt_r == UPDATE_LAST) begin
                        upd_cnt_nxt_s  = '0;
                        wait_cnt_nxt_s = '0;
                        conv_en_nxt_s  = 1'b1;
                        state_nxt_s    = REQ_WAIT;
                    end else begin
                        upd_cnt_nxt_s  = upd_cnt_r + UW'(1);
                    end
                end else begin
                    upd_cnt_nxt_s = upd_cnt_r;
                end
            end
            REQ_WAIT: begin
                wait_cnt_nxt_s = wait_cnt_r + TW'(1);
                if (bcd_vld) begin
                    stale_nxt_s = 1'b0;
                    state_nxt_s = REQ_IDLE;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    stale_nxt_s = 1'b1;
                    state_nxt_s = REQ_IDLE;
                end else begin
                    state_nxt_s = REQ_WAIT;
                end
            end
            default: begin
                state_nxt_s = REQ_IDLE;
            end
        endcase
    end

    // Request FSM state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= REQ_IDLE;
            upd_cnt_r  <= '0;
            wait_cnt_r <= '0;
            conv_en_r  <= 1'b0;
            stale_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            upd_cnt_r  <= upd_cnt_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            conv_en_r  <= conv_en_nxt_s;
            stale_r    <= stale_nxt_s;
        end
    end

    assign conv_en = conv_en_r;
    assign stale   = stale_r;
    assign an_n    = an_n_r;
    assign seg_n   = seg_n_r;
    assign dp_n    = dp_n_r;

endmodule
